// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM command/data port between NR merge-tree
// readers and a single result writer. One transaction at a time; the owner
// gets a grant pulse, its data strobes routed through, and a done pulse.
`ifndef DRAM_REQ_READ
`define DRAM_REQ_READ  2'b01
`endif
`ifndef DRAM_REQ_WRITE
`define DRAM_REQ_WRITE 2'b10
`endif

module dram_port_arbiter #(
    parameter int NR   = 4,
    parameter int ADRW = 32,
    parameter int BLKW = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NR-1:0]        R_REQ,
    input  logic [NR*ADRW-1:0]   R_ADR,
    input  logic [NR*BLKW-1:0]   R_BLK,
    output logic [NR-1:0]        R_GNT,
    output logic [NR-1:0]        R_DEN,
    output logic [NR-1:0]        R_DONE,
    input  logic                 W_REQ,
    input  logic [ADRW-1:0]      W_ADR,
    input  logic [BLKW-1:0]      W_BLK,
    output logic                 W_GNT,
    output logic                 W_DEQ,
    output logic                 W_DONE,
    input  logic                 D_BUSY,
    input  logic                 D_W,
    input  logic                 D_DOUTEN,
    output logic [1:0]           D_REQ,
    output logic [ADRW-1:0]      D_INITADR,
    output logic [BLKW-1:0]      D_BLOCKS,
    output logic                 BUSY,
    output logic                 ERR
);
    localparam int IW = $clog2(NR);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_ZERO} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   own_q, own_d;
    logic            wr_q, wr_d;
    logic            last_w_q, last_w_d;
    logic [ADRW-1:0] adr_q, adr_d;
    logic [BLKW-1:0] blk_q, blk_d;
    logic [BLKW-1:0] cnt_q, cnt_d;
    logic [NR-1:0]   rdone_q, rdone_d;
    logic            wdone_q, wdone_d;
    logic            err_q, err_d;

    logic [NR-1:0]   own_oh;
    logic            idle, own_ev, over, route, bad_dir, fin, gnt_cyc;
    logic [BLKW-1:0] cnt_inc;
    logic            rd_hit;
    logic [IW-1:0]   rd_sel, cand;

    // Round-robin search over readers, starting one past the last granted index.
    always_comb begin
        rd_hit = 1'b0;
        rd_sel = '0;
        cand   = '0;
        for (int k = 1; k <= NR; k++) begin
            cand = IW'((int'(ptr_q) + k) % NR);
            if (!rd_hit && R_REQ[cand]) begin
                rd_hit = 1'b1;
                rd_sel = cand;
            end
        end
    end

    // Data-strobe decode: which events belong to the owner, which are violations.
    // Owner events are accepted from ISSUE onward so an early strobe is not lost.
    always_comb begin
        idle    = (state_q == S_IDLE);
        own_oh  = NR'(1) << own_q;
        bad_dir = (D_DOUTEN && (idle || wr_q)) || (D_W && (idle || !wr_q));
        own_ev  = !idle && (wr_q ? D_W : D_DOUTEN);
        over    = own_ev && (cnt_q >= blk_q);
        route   = own_ev && !over;
        cnt_inc = cnt_q + BLKW'(route);
        fin     = (state_q == S_XFER) && (cnt_inc == blk_q) && !D_BUSY;
    end

    // Next-state logic; writer wins unless it just had the port and a reader waits.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        wr_d     = wr_q;
        last_w_d = last_w_q;
        adr_d    = adr_q;
        blk_d    = blk_q;
        cnt_d    = cnt_q;
        rdone_d  = '0;
        wdone_d  = 1'b0;
        err_d    = err_q | bad_dir | over;
        case (state_q)
            S_IDLE: begin
                if (!D_BUSY && (W_REQ || rd_hit)) begin
                    cnt_d = '0;
                    if (W_REQ && !(last_w_q && rd_hit)) begin
                        wr_d     = 1'b1;
                        last_w_d = 1'b1;
                        own_d    = '0;
                        adr_d    = W_ADR;
                        blk_d    = W_BLK;
                    end else begin
                        wr_d     = 1'b0;
                        last_w_d = 1'b0;
                        own_d    = rd_sel;
                        ptr_d    = rd_sel;
                        adr_d    = R_ADR[rd_sel*ADRW +: ADRW];
                        blk_d    = R_BLK[rd_sel*BLKW +: BLKW];
                    end
                    state_d = (blk_d == '0) ? S_ZERO : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_inc;
                state_d = S_XFER;
            end
            S_XFER: begin
                cnt_d = cnt_inc;
                if (fin) begin
                    state_d = S_IDLE;
                    rdone_d = wr_q ? '0 : own_oh;
                    wdone_d = wr_q;
                end
            end
            S_ZERO: begin
                state_d = S_IDLE;
                rdone_d = wr_q ? '0 : own_oh;
                wdone_d = wr_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and transaction registers; reset drops any transaction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            ptr_q    <= IW'(NR - 1);
            own_q    <= '0;
            wr_q     <= 1'b0;
            last_w_q <= 1'b0;
            adr_q    <= '0;
            blk_q    <= '0;
            cnt_q    <= '0;
            rdone_q  <= '0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            own_q    <= own_d;
            wr_q     <= wr_d;
            last_w_q <= last_w_d;
            adr_q    <= adr_d;
            blk_q    <= blk_d;
            cnt_q    <= cnt_d;
            rdone_q  <= rdone_d;
            wdone_q  <= wdone_d;
            err_q    <= err_d;
        end
    end

    // Output decode: grant in the first busy cycle, command only when blocks > 0.
    always_comb begin
        gnt_cyc   = (state_q == S_ISSUE) || (state_q == S_ZERO);
        R_GNT     = (gnt_cyc && !wr_q) ? own_oh : '0;
        W_GNT     = gnt_cyc && wr_q;
        R_DEN     = (route && !wr_q) ? own_oh : '0;
        W_DEQ     = route && wr_q;
        R_DONE    = rdone_q;
        W_DONE    = wdone_q;
        D_REQ     = (state_q == S_ISSUE) ? (wr_q ? `DRAM_REQ_WRITE : `DRAM_REQ_READ) : 2'b00;
        D_INITADR = (state_q == S_ISSUE || state_q == S_XFER) ? adr_q : '0;
        D_BLOCKS  = (state_q == S_ISSUE || state_q == S_XFER) ? blk_q : '0;
        BUSY      = !idle;
        ERR       = err_q;
    end

endmodule
